// File: rtl/seg7_pkg.sv
// Shared seven-segment constants and the nibble-to-glyph decode function.
// Segment order is {g,f,e,d,c,b,a}, active-low (common-anode display).
package seg7_pkg;

    typedef logic [1:0] scan_idx_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] GLYPH_0   = 7'b1000000;
    localparam logic [6:0] GLYPH_1   = 7'b1111001;
    localparam logic [6:0] GLYPH_2   = 7'b0100100;
    localparam logic [6:0] GLYPH_3   = 7'b0110000;
    localparam logic [6:0] GLYPH_4   = 7'b0011001;
    localparam logic [6:0] GLYPH_5   = 7'b0010010;
    localparam logic [6:0] GLYPH_6   = 7'b0000010;
    localparam logic [6:0] GLYPH_7   = 7'b1111000;
    localparam logic [6:0] GLYPH_8   = 7'b0000000;
    localparam logic [6:0] GLYPH_9   = 7'b0010000;

    // Non-decimal nibbles render as a dash so a corrupted BCD word is visible.
    function automatic logic [6:0] seg7_decode(input logic [3:0] nibble);
        logic [6:0] glyph;
        case (nibble)
            4'd0:    glyph = GLYPH_0;
            4'd1:    glyph = GLYPH_1;
            4'd2:    glyph = GLYPH_2;
            4'd3:    glyph = GLYPH_3;
            4'd4:    glyph = GLYPH_4;
            4'd5:    glyph = GLYPH_5;
            4'd6:    glyph = GLYPH_6;
            4'd7:    glyph = GLYPH_7;
            4'd8:    glyph = GLYPH_8;
            4'd9:    glyph = GLYPH_9;
            default: glyph = SEG_DASH;
        endcase
        return glyph;
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to active-low seven-segment decoder.
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    assign seg = seg7_decode(digit);

endmodule

// File: rtl/seg7_scan.sv
// Four-digit multiplexed seven-segment driver with frame-coherent updates
// and optional leading-zero blanking.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] bcd_in,
    input  logic        load,
    input  logic        blank_lz,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int PW = $clog2(REFRESH_DIV);

    logic [PW-1:0] presc_r;
    scan_idx_t     idx_r;
    logic [15:0]   pending_r;
    logic [15:0]   shown_r;
    logic [3:0]    an_r;
    logic [6:0]    seg_r;
    logic          dp_r;

    logic          tick_s;
    logic          frame_s;
    logic [3:0]    digit_s;
    logic [6:0]    glyph_s;
    logic          blank_s;
    logic [3:0]    an_nxt_s;
    logic [6:0]    seg_nxt_s;

    assign tick_s  = (presc_r == PW'(REFRESH_DIV - 1));
    assign frame_s = tick_s && (idx_r == 2'd3);

    // Prescaler and scan index
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_r <= '0;
            idx_r   <= 2'd0;
        end else if (tick_s) begin
            presc_r <= '0;
            idx_r   <= idx_r + 2'd1;
        end else begin
            presc_r <= presc_r + PW'(1);
        end
    end

    // Pending capture and frame-boundary transfer; a coincident load bypasses pending
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_r <= 16'h0000;
            shown_r   <= 16'h0000;
        end else begin
            if (load) begin
                pending_r <= bcd_in;
            end
            if (frame_s) begin
                shown_r <= load ? bcd_in : pending_r;
            end
        end
    end

    // Digit select and leading-zero blanking for the current slot
    always_comb begin
        digit_s = 4'd0;
        blank_s = 1'b0;
        case (idx_r)
            2'd0: begin
                digit_s = shown_r[3:0];
                blank_s = 1'b0;
            end
            2'd1: begin
                digit_s = shown_r[7:4];
                blank_s = blank_lz && (shown_r[15:4] == 12'h000);
            end
            2'd2: begin
                digit_s = shown_r[11:8];
                blank_s = blank_lz && (shown_r[15:8] == 8'h00);
            end
            2'd3: begin
                digit_s = shown_r[15:12];
                blank_s = blank_lz && (shown_r[15:12] == 4'h0);
            end
            default: begin
                digit_s = 4'd0;
                blank_s = 1'b0;
            end
        endcase
    end

    bcd_to_seg7 u_dec (
        .digit (digit_s),
        .seg   (glyph_s)
    );

    // Next anode/segment pattern
    always_comb begin
        an_nxt_s  = 4'b1111;
        seg_nxt_s = SEG_BLANK;
        if (blank_s) begin
            an_nxt_s  = 4'b1111;
            seg_nxt_s = SEG_BLANK;
        end else begin
            an_nxt_s  = ~(4'b0001 << idx_r);
            seg_nxt_s = glyph_s;
        end
    end

    // Output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an_r  <= 4'b1111;
            seg_r <= SEG_BLANK;
            dp_r  <= 1'b1;
        end else begin
            an_r  <= an_nxt_s;
            seg_r <= seg_nxt_s;
            dp_r  <= 1'b1;
        end
    end

    assign an  = an_r;
    assign seg = seg_r;
    assign dp  = dp_r;

endmodule
